// File: rtl/muldiv_ctrl_if.sv
// Handshake/bus bundle for the EXE-stage multiply/divide controller.
// Carries the ES request, the HI/LO write port and the AXI-stream links to
// the signed and unsigned divider IPs.
//   slave  : controller view (muldiv_ctrl)
//   master : environment view (pipeline stage + divider IPs)
interface muldiv_ctrl_if;
  // ES request side
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        es_leave;
  logic        cancel;
  logic        stall;
  logic        busy;
  // HI/LO write port
  logic [1:0]  hl_we;
  logic [31:0] h_wdata;
  logic [31:0] l_wdata;
  // divider operand channels
  logic        div_tvalid;
  logic        div_tready;
  logic        divu_tvalid;
  logic        divu_tready;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  // divider result channels
  logic        div_dout_tvalid;
  logic [63:0] div_dout;
  logic        divu_dout_tvalid;
  logic [63:0] divu_dout;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, es_leave, cancel,
    input  div_tready, divu_tready,
    input  div_dout_tvalid, div_dout, divu_dout_tvalid, divu_dout,
    output stall, busy, hl_we, h_wdata, l_wdata,
    output div_tvalid, divu_tvalid, div_src1, div_src2
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, es_leave, cancel,
    output div_tready, divu_tready,
    output div_dout_tvalid, div_dout, divu_dout_tvalid, divu_dout,
    input  stall, busy, hl_we, h_wdata, l_wdata,
    input  div_tvalid, divu_tvalid, div_src1, div_src2
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// EXE-stage multiply/divide sequencer.
// Accepts one MULT/MULTU/DIV/DIVU at a time, runs multiplies through a
// MUL_LAT-cycle pipeline and divides through the external signed/unsigned
// divider IPs, stalls ES until the result is ready and writes HI/LO exactly
// once per instruction. Cancellation drains a divide already handed to an IP.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus    - muldiv_ctrl_if.slave (ES request, HI/LO write, divider streams)
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_ISSUE, S_WAIT, S_DRAIN, S_WB, S_HOLD
  } state_t;

  // last counter value spent in S_MUL (accepting cycle is cycle 1)
  localparam logic [3:0] CNT_LAST = (MUL_LAT >= 2) ? 4'(MUL_LAT - 2) : '0;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_is_divu;
  logic [3:0]  r_cnt;

  logic        w_accept;
  logic        w_mul_op;
  logic        w_tready;
  logic        w_dout_v;
  logic [63:0] w_dout;
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_prod;

  assign w_accept = bus.req_valid & (|bus.req_op) & ~bus.cancel;
  assign w_mul_op = bus.req_op[0] | bus.req_op[1];

  // 33x33 signed product of {sign-or-zero, src}; only mult sign-extends.
  // Operands are widened to 64 bits so the low 64 product bits are exact.
  assign w_a    = {{32{bus.req_op[0] & bus.req_src1[31]}}, bus.req_src1};
  assign w_b    = {{32{bus.req_op[0] & bus.req_src2[31]}}, bus.req_src2};
  assign w_prod = w_a * w_b;

  // only the divider selected by the captured op is ever observed
  assign w_tready = r_is_divu ? bus.divu_tready      : bus.div_tready;
  assign w_dout_v = r_is_divu ? bus.divu_dout_tvalid : bus.div_dout_tvalid;
  assign w_dout   = r_is_divu ? bus.divu_dout        : bus.div_dout;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mul_op) w_next = (MUL_LAT == 1) ? S_WB : S_MUL;
          else          w_next = S_ISSUE;
        end
      end
      S_MUL: begin
        if (bus.cancel)            w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_WB;
      end
      S_ISSUE: begin
        // an operand already taken by the IP cannot be aborted
        if (bus.cancel)    w_next = w_tready ? S_DRAIN : S_IDLE;
        else if (w_tready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cancel)    w_next = w_dout_v ? S_IDLE : S_DRAIN;
        else if (w_dout_v) w_next = S_WB;
      end
      S_DRAIN: begin
        if (w_dout_v) w_next = S_IDLE;
      end
      S_WB: begin
        w_next = (bus.es_leave | bus.cancel) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (bus.es_leave | bus.cancel) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // operand, op and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src1    <= '0;
      r_src2    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_divu <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_src1    <= bus.req_src1;
        r_src2    <= bus.req_src2;
        r_is_divu <= ~(|bus.req_op[2:0]);
        r_cnt     <= '0;
        // product enters the pipeline on the accepting cycle
        if (w_mul_op) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
      end
      if (r_state == S_MUL) r_cnt <= r_cnt + 4'd1;
      if (r_state == S_WAIT && w_dout_v && !bus.cancel) begin
        r_hi <= w_dout[31:0];   // remainder
        r_lo <= w_dout[63:32];  // quotient
      end
    end
  end

  // outputs
  always_comb begin
    bus.stall       = 1'b0;
    bus.busy        = (r_state != S_IDLE);
    bus.hl_we       = 2'b00;
    bus.div_tvalid  = 1'b0;
    bus.divu_tvalid = 1'b0;
    unique case (r_state)
      S_IDLE:        bus.stall = bus.req_valid & (|bus.req_op);
      S_WB: begin
        bus.hl_we = {2{~bus.cancel}};
      end
      S_HOLD:        bus.stall = 1'b0;
      S_ISSUE: begin
        bus.stall       = bus.req_valid;
        bus.div_tvalid  = ~r_is_divu;
        bus.divu_tvalid = r_is_divu;
      end
      default:       bus.stall = bus.req_valid;
    endcase
    // stall is combinational from req_valid, so hold it low during reset
    bus.stall = bus.stall & reset;
  end

  assign bus.h_wdata  = r_hi;
  assign bus.l_wdata  = r_lo;
  assign bus.div_src1 = r_src1;
  assign bus.div_src2 = r_src2;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, expected HI/LO
// writes queued at issue time and checked by an independent write monitor.
module tb_muldiv_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [63:0] exp_q[$];

  muldiv_ctrl_if mif();

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.req_valid = 1'b1;
    mif.req_op    = op;
    mif.req_src1  = a;
    mif.req_src2  = b;
  endtask

  task automatic leave();
    mif.es_leave = 1'b1;
    tick();
    mif.es_leave  = 1'b0;
    mif.req_valid = 1'b0;
    mif.req_op    = 4'd0;
  endtask

  // counts stalled cycles until the write-back cycle (first non-stall cycle)
  task automatic wait_wb(input int exp_stall, input string nm);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mif.stall) begin
        hit = 1'b1;
        break;
      end
      n++;
      tick();
    end
    check({nm, "_reached_wb"}, 64'(hit), 64'd1);
    check({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_stall"},       64'(mif.stall),       64'd0);
    check({nm, "_busy"},        64'(mif.busy),        64'd0);
    check({nm, "_hl_we"},       64'(mif.hl_we),       64'd0);
    check({nm, "_h_wdata"},     64'(mif.h_wdata),     64'd0);
    check({nm, "_l_wdata"},     64'(mif.l_wdata),     64'd0);
    check({nm, "_div_tvalid"},  64'(mif.div_tvalid),  64'd0);
    check({nm, "_divu_tvalid"}, 64'(mif.divu_tvalid), 64'd0);
    check({nm, "_div_src1"},    64'(mif.div_src1),    64'd0);
    check({nm, "_div_src2"},    64'(mif.div_src2),    64'd0);
  endtask

  // write monitor: every HI/LO write must match the oldest queued result
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mif.hl_we !== 2'b00) begin
        check("hl_we_pulse", 64'(mif.hl_we), 64'd3);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_write: hl_we=%b h=%h l=%h expected no write",
                   mif.hl_we, mif.h_wdata, mif.l_wdata);
        end else begin
          e = exp_q.pop_front();
          check("h_wdata", 64'(mif.h_wdata), 64'(e[63:32]));
          check("l_wdata", 64'(mif.l_wdata), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    mif.req_valid        = 1'b1;
    mif.req_op           = 4'b0001;
    mif.req_src1         = 32'd0;
    mif.req_src2         = 32'd0;
    mif.es_leave         = 1'b0;
    mif.cancel           = 1'b0;
    mif.div_tready       = 1'b0;
    mif.divu_tready      = 1'b0;
    mif.div_dout_tvalid  = 1'b0;
    mif.div_dout         = 64'd0;
    mif.divu_dout_tvalid = 1'b0;
    mif.divu_dout        = 64'd0;

    // reset state, with a request pending to show stall is held low
    #12;
    check_zero("reset");
    @(negedge clk);
    mif.req_valid = 1'b0;
    mif.req_op    = 4'd0;
    reset         = 1'b1;
    tick();

    // MULT -2 * 3
    drive(4'b0001, 32'hFFFFFFFE, 32'd3);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    wait_wb(2, "mult");
    leave();

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF
    drive(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    exp_q.push_back(64'hFFFFFFFE_00000001);
    wait_wb(2, "multu");
    leave();

    // DIV -7 / 2, tready after 3 cycles of tvalid, result 5 cycles later
    drive(4'b0100, 32'hFFFFFFF9, 32'd2);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    @(negedge clk);
    check("div_accept_stall", 64'(mif.stall), 64'd1);
    check("div_idle_tvalid", 64'(mif.div_tvalid), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mif.div_tready = 1'b1;
      @(negedge clk);
      check("div_issue_tvalid", 64'(mif.div_tvalid), 64'd1);
      check("div_issue_divu_tvalid", 64'(mif.divu_tvalid), 64'd0);
      check("div_issue_src1", 64'(mif.div_src1), 64'h0000_0000_FFFF_FFF9);
      check("div_issue_src2", 64'(mif.div_src2), 64'd2);
      tick();
    end
    mif.div_tready = 1'b0;
    // result from the other divider must be ignored
    mif.divu_dout_tvalid = 1'b1;
    mif.divu_dout        = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check("div_wait_tvalid", 64'(mif.div_tvalid), 64'd0);
    check("div_wait_stall", 64'(mif.stall), 64'd1);
    tick();
    mif.divu_dout_tvalid = 1'b0;
    tick();
    tick();
    tick();
    mif.div_dout_tvalid = 1'b1;
    mif.div_dout        = {32'hFFFFFFFD, 32'hFFFFFFFF};
    tick();
    mif.div_dout_tvalid = 1'b0;
    wait_wb(0, "div");
    leave();

    // DIVU 100 / 7 with ES blocked after write-back
    mif.divu_tready = 1'b1;
    drive(4'b1000, 32'd100, 32'd7);
    exp_q.push_back(64'h00000002_0000000E);
    tick();
    @(negedge clk);
    check("divu_issue_tvalid", 64'(mif.divu_tvalid), 64'd1);
    check("divu_issue_div_tvalid", 64'(mif.div_tvalid), 64'd0);
    tick();
    mif.divu_tready      = 1'b0;
    mif.div_dout_tvalid  = 1'b1;
    mif.div_dout         = 64'hFFFF_0000_FFFF_0000;
    tick();
    mif.div_dout_tvalid  = 1'b0;
    mif.divu_dout_tvalid = 1'b1;
    mif.divu_dout        = {32'd14, 32'd2};
    tick();
    mif.divu_dout_tvalid = 1'b0;
    @(negedge clk);
    check("divu_wb_stall", 64'(mif.stall), 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_hl_we", 64'(mif.hl_we), 64'd0);
      check("hold_stall", 64'(mif.stall), 64'd0);
      check("hold_busy", 64'(mif.busy), 64'd1);
      check("hold_divu_tvalid", 64'(mif.divu_tvalid), 64'd0);
      if (i == 4) mif.es_leave = 1'b1;
      tick();
    end
    mif.es_leave  = 1'b0;
    mif.req_valid = 1'b0;
    mif.req_op    = 4'd0;
    @(negedge clk);
    check("hold_exit_busy", 64'(mif.busy), 64'd0);
    tick();

    // DIV taken by the IP, cancelled in WAIT, new MULT waits out the drain
    mif.div_tready = 1'b1;
    drive(4'b0100, 32'd10, 32'd3);
    @(negedge clk);
    check("cdiv_accept_stall", 64'(mif.stall), 64'd1);
    tick();
    @(negedge clk);
    check("cdiv_issue_tvalid", 64'(mif.div_tvalid), 64'd1);
    tick();
    mif.div_tready = 1'b0;
    mif.cancel     = 1'b1;
    mif.req_valid  = 1'b0;
    mif.req_op     = 4'd0;
    @(negedge clk);
    check("cdiv_wait_busy", 64'(mif.busy), 64'd1);
    tick();
    mif.cancel = 1'b0;
    drive(4'b0001, 32'd5, 32'd6);
    exp_q.push_back(64'd30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drain_stall", 64'(mif.stall), 64'd1);
      check("drain_busy", 64'(mif.busy), 64'd1);
      check("drain_tvalid", 64'(mif.div_tvalid), 64'd0);
      tick();
    end
    mif.div_dout_tvalid = 1'b1;
    mif.div_dout        = 64'h00000003_00000001;
    @(negedge clk);
    check("drain_last_stall", 64'(mif.stall), 64'd1);
    tick();
    mif.div_dout_tvalid = 1'b0;
    wait_wb(2, "mult_after_drain");
    leave();

    // MULT cancelled in flight: no write, back to idle
    drive(4'b0001, 32'd7, 32'd7);
    tick();
    mif.cancel    = 1'b1;
    mif.req_valid = 1'b0;
    mif.req_op    = 4'd0;
    @(negedge clk);
    check("cmul_busy", 64'(mif.busy), 64'd1);
    tick();
    mif.cancel = 1'b0;
    @(negedge clk);
    check("cmul_idle_busy", 64'(mif.busy), 64'd0);
    tick();

    // req_op == 0 is ignored without stalling
    mif.req_valid = 1'b1;
    mif.req_op    = 4'd0;
    @(negedge clk);
    check("op0_stall", 64'(mif.stall), 64'd0);
    tick();
    @(negedge clk);
    check("op0_busy", 64'(mif.busy), 64'd0);
    mif.req_valid = 1'b0;
    tick();

    // reset asserted while a DIVU waits for its result
    mif.divu_tready = 1'b1;
    drive(4'b1000, 32'd9, 32'd4);
    tick();
    tick();
    mif.divu_tready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    mif.req_valid = 1'b0;
    mif.req_op    = 4'd0;
    reset         = 1'b1;
    tick();
    drive(4'b0001, 32'h0001_0000, 32'h0001_0000);
    exp_q.push_back(64'h00000001_00000000);
    wait_wb(2, "mult_after_reset");
    leave();

    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
